// File: rtl/matrix_pkg.sv
// Shared constants, opcodes, state encoding and opcode helpers for the matrix loader.
package matrix_pkg;

    localparam int MAT_DIM = 5;
    localparam int ELEM_W  = 8;
    localparam int FLAT_W  = 200;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_SUM  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_OPP  = 3'b100;
    localparam logic [2:0] OP_TRN  = 3'b101;
    localparam logic [2:0] OP_SCL  = 3'b110;
    localparam logic [2:0] OP_DET  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_EXEC   = 2'd3
    } state_t;

    function automatic logic is_binary_op(input logic [2:0] op);
        return (op == OP_SUM) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/matrix_elem_packer.sv
// Packs a row-major element stream of an N x N matrix into a zero-padded 5x5 flat register.
module matrix_elem_packer
    import matrix_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              wr_i,
    input  logic [2:0]        size_i,
    input  logic [ELEM_W-1:0] data_i,
    output logic [FLAT_W-1:0] flat_o,
    output logic              last_o
);

    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic [4:0]        slot;
    logic              col_wrap;
    logic [ELEM_W-1:0] elem_q [MAT_DIM*MAT_DIM];

    assign slot     = ({2'b00, row_q} * 5'd5) + {2'b00, col_q};
    assign col_wrap = (col_q == size_i - 3'd1);
    assign last_o   = wr_i && col_wrap && (row_q == size_i - 3'd1);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (wr_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    // One register per 5x5 slot; only the slot addressed by (r,c) captures a transfer.
    generate
        for (genvar gi = 0; gi < MAT_DIM*MAT_DIM; gi++) begin : g_slot
            always_ff @(posedge clock) begin
                if (reset || clear_i) begin
                    elem_q[gi] <= '0;
                end else if (wr_i && (slot == 5'(gi))) begin
                    elem_q[gi] <= data_i;
                end
            end
            assign flat_o[ELEM_W*gi +: ELEM_W] = elem_q[gi];
        end
    endgenerate

endmodule

// File: rtl/matrix_loader.sv
// Command/element feeder for the matrix ALU: loads A (and B for binary ops), then runs an EXEC window.
// Optional abort input enabled by defining MATRIX_LOADER_ABORT_EN.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int EXEC_CYCLES = 2
)
(
    input  logic              clock,
    input  logic              reset,
`ifdef MATRIX_LOADER_ABORT_EN
    input  logic              abort,
`endif
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [7:0]        cmd_scalar,
    input  logic [2:0]        cmd_size,
    input  logic              elem_valid,
    output logic              elem_ready,
    input  logic [ELEM_W-1:0] elem_data,
    output logic [FLAT_W-1:0] A_flat,
    output logic [FLAT_W-1:0] B_flat,
    output logic [7:0]        f,
    output logic [2:0]        opcode,
    output logic              result_strobe,
    output logic              busy,
    output logic              cmd_error
);

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);
    localparam logic [3:0] EXEC_PRE  = 4'(EXEC_CYCLES - 2);

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] size_q, size_d;
    logic [7:0] f_q, f_d;
    logic [3:0] exec_cnt_q, exec_cnt_d;
    logic [2:0] opcode_q, opcode_d;
    logic       strobe_q, strobe_d;
    logic       err_q, err_d;
    logic       clear, wr_a, wr_b, last_a, last_b, abort_w, cmd_bad;

`ifdef MATRIX_LOADER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign cmd_ready  = (state_q == ST_IDLE);
    assign elem_ready = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign busy       = (state_q != ST_IDLE);
    assign cmd_bad    = (cmd_op == OP_NONE) || (cmd_size == 3'd0) || (cmd_size > 3'd5);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        size_d     = size_q;
        f_d        = f_q;
        exec_cnt_d = '0;
        opcode_d   = OP_NONE;
        strobe_d   = 1'b0;
        err_d      = 1'b0;
        clear      = 1'b0;
        wr_a       = 1'b0;
        wr_b       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = cmd_op;
                        size_d  = cmd_size;
                        f_d     = cmd_scalar;
                        clear   = 1'b1;
                        state_d = ST_LOAD_A;
                    end
                end
            end
            ST_LOAD_A: begin
                wr_a = elem_valid;
                if (last_a) begin
                    if (is_binary_op(op_q)) begin
                        state_d = ST_LOAD_B;
                    end else begin
                        state_d  = ST_EXEC;
                        opcode_d = op_q;
                    end
                end
            end
            ST_LOAD_B: begin
                wr_b = elem_valid;
                if (last_b) begin
                    state_d  = ST_EXEC;
                    opcode_d = op_q;
                end
            end
            ST_EXEC: begin
                exec_cnt_d = exec_cnt_q + 4'd1;
                opcode_d   = op_q;
                // Registered strobe: set one cycle early so it lands in the final EXEC cycle.
                strobe_d   = (exec_cnt_q == EXEC_PRE);
                if (exec_cnt_q == EXEC_LAST) begin
                    state_d    = ST_IDLE;
                    opcode_d   = OP_NONE;
                    exec_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_w && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            opcode_d   = OP_NONE;
            strobe_d   = 1'b0;
            exec_cnt_d = '0;
            wr_a       = 1'b0;
            wr_b       = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NONE;
            size_q     <= '0;
            f_q        <= '0;
            exec_cnt_q <= '0;
            opcode_q   <= OP_NONE;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            size_q     <= size_d;
            f_q        <= f_d;
            exec_cnt_q <= exec_cnt_d;
            opcode_q   <= opcode_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
        end
    end

    matrix_elem_packer u_pack_a (
        .clock   (clock),
        .reset   (reset),
        .clear_i (clear),
        .wr_i    (wr_a),
        .size_i  (size_q),
        .data_i  (elem_data),
        .flat_o  (A_flat),
        .last_o  (last_a)
    );

    matrix_elem_packer u_pack_b (
        .clock   (clock),
        .reset   (reset),
        .clear_i (clear),
        .wr_i    (wr_b),
        .size_i  (size_q),
        .data_i  (elem_data),
        .flat_o  (B_flat),
        .last_o  (last_b)
    );

    assign f             = f_q;
    assign opcode        = opcode_q;
    assign result_strobe = strobe_q;
    assign cmd_error     = err_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_matrix_loader;
    import matrix_pkg::*;

    localparam int EXEC_CYCLES = 2;

    logic         clock;
    logic         reset;
    logic         abort;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [7:0]   cmd_scalar;
    logic [2:0]   cmd_size;
    logic         elem_valid;
    logic         elem_ready;
    logic [7:0]   elem_data;
    logic [199:0] A_flat;
    logic [199:0] B_flat;
    logic [7:0]   f;
    logic [2:0]   opcode;
    logic         result_strobe;
    logic         busy;
    logic         cmd_error;

    matrix_loader #(.EXEC_CYCLES(EXEC_CYCLES)) dut (
        .clock         (clock),
        .reset         (reset),
`ifdef MATRIX_LOADER_ABORT_EN
        .abort         (abort),
`endif
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_scalar    (cmd_scalar),
        .cmd_size      (cmd_size),
        .elem_valid    (elem_valid),
        .elem_ready    (elem_ready),
        .elem_data     (elem_data),
        .A_flat        (A_flat),
        .B_flat        (B_flat),
        .f             (f),
        .opcode        (opcode),
        .result_strobe (result_strobe),
        .busy          (busy),
        .cmd_error     (cmd_error)
    );

    typedef struct {
        logic         is_err;
        logic [2:0]   op;
        logic [199:0] a;
        logic [199:0] b;
        logic [7:0]   f;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    int           run_len = 0;
    logic [7:0]   a_vals[25];
    logic [7:0]   b_vals[25];
    int           gaps[25];
    logic [199:0] last_a;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [199:0] put(input logic [199:0] flat, input int k, input int n,
                                         input logic [7:0] v);
        int slot;
        slot = 5 * (k / n) + (k % n);
        flat[slot*8 +: 8] = v;
        return flat;
    endfunction

    // Monitor: each strobe or error pulse consumes one scoreboard entry.
    always @(negedge clock) begin
        if (reset) begin
            run_len = 0;
        end else begin
            if (opcode != 3'b000) run_len++;
            else run_len = 0;
            if (result_strobe || cmd_error) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=strobe%0b_err%0b required=none",
                             result_strobe, cmd_error);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("err_pulse", 200'(cmd_error), 200'(mon_e.is_err));
                    chk("strobe", 200'(result_strobe), 200'(!mon_e.is_err));
                    if (!mon_e.is_err) begin
                        chk("opcode_at_strobe", 200'(opcode), 200'(mon_e.op));
                        chk("exec_len", 200'(run_len), 200'(EXEC_CYCLES));
                    end
                    chk("A_flat", A_flat, mon_e.a);
                    chk("B_flat", B_flat, mon_e.b);
                    chk("f", 200'(f), 200'(mon_e.f));
                    $display("txn err=%0b op=%0d A=%0h B=%0h f=%0h", cmd_error, opcode, A_flat, B_flat, f);
                end
            end
        end
    end

    task automatic wait_cmd_ready();
        int n = 0;
        while (!cmd_ready && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 200'(cmd_ready), 200'(1));
    endtask

    task automatic wait_elem_ready();
        int n = 0;
        while (!elem_ready && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        if (!elem_ready) chk("elem_ready_timeout", 200'(elem_ready), 200'(1));
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] scl, input logic [2:0] size);
        wait_cmd_ready();
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_scalar = scl;
        cmd_size   = size;
        @(posedge clock); #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic send_elem(input logic [7:0] data, input int gap);
        elem_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock); #1;
        end
        wait_elem_ready();
        elem_valid = 1'b1;
        elem_data  = data;
        @(posedge clock); #1;
        elem_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] scl, input int n, input bit use_gaps);
        exp_t e;
        bit   binop;
        binop  = (op == 3'b001) || (op == 3'b010) || (op == 3'b011);
        e.is_err = 1'b0;
        e.op     = op;
        e.a      = '0;
        e.b      = '0;
        e.f      = scl;
        for (int k = 0; k < n*n; k++) begin
            e.a = put(e.a, k, n, a_vals[k]);
            if (binop) e.b = put(e.b, k, n, b_vals[k]);
        end
        last_a = e.a;
        sb_q.push_back(e);
        send_cmd(op, scl, 3'(n));
        @(negedge clock);
        chk("elem_ready_after_accept", 200'(elem_ready), 200'(1));
        chk("busy_after_accept", 200'(busy), 200'(1));
        for (int k = 0; k < n*n; k++) begin
            if (use_gaps && k == 4) begin
                chk("cmd_ready_in_load", 200'(cmd_ready), 200'(0));
                cmd_valid = 1'b1;
                cmd_op    = 3'b101;
                cmd_size  = 3'd1;
            end
            send_elem(a_vals[k], use_gaps ? gaps[k] : 0);
            cmd_valid = 1'b0;
        end
        if (binop) begin
            for (int k = 0; k < n*n; k++) send_elem(b_vals[k], use_gaps ? gaps[k] : 0);
        end
        @(negedge clock);
        chk("opcode_first_exec", 200'(opcode), 200'(op));
        wait_cmd_ready();
    endtask

    task automatic illegal_cmd(input logic [2:0] op, input logic [7:0] scl, input logic [2:0] size,
                               input logic [7:0] exp_f);
        exp_t e;
        e.is_err = 1'b1;
        e.op     = 3'b000;
        e.a      = last_a;
        e.b      = '0;
        e.f      = exp_f;
        sb_q.push_back(e);
        send_cmd(op, scl, size);
        @(negedge clock);
        chk("busy_after_illegal", 200'(busy), 200'(0));
        chk("cmd_ready_after_illegal", 200'(cmd_ready), 200'(1));
    endtask

    initial begin
        reset      = 1'b1;
        abort      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 3'b000;
        cmd_scalar = 8'h00;
        cmd_size   = 3'd0;
        elem_valid = 1'b0;
        elem_data  = 8'h00;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_A", A_flat, 200'h0);
        chk("rst_B", B_flat, 200'h0);
        chk("rst_f", 200'(f), 200'h0);
        chk("rst_opcode", 200'(opcode), 200'h0);
        chk("rst_busy", 200'(busy), 200'h0);
        chk("rst_cmd_ready", 200'(cmd_ready), 200'h1);

        // 1: sum N=2, checked also at explicit bit positions
        a_vals[0] = 8'd1;  a_vals[1] = 8'd2;  a_vals[2] = 8'd3;  a_vals[3] = 8'd4;
        b_vals[0] = 8'd10; b_vals[1] = 8'd20; b_vals[2] = 8'd30; b_vals[3] = 8'd40;
        run_cmd(3'b001, 8'h00, 2, 1'b0);
        chk("s1_A_slot6", 200'(A_flat[55:48]), 200'd4);
        chk("s1_A_slot5", 200'(A_flat[47:40]), 200'd3);
        chk("s1_B_slot6", 200'(B_flat[55:48]), 200'd40);

        // 2: scalar, N=5, full matrix
        for (int k = 0; k < 25; k++) a_vals[k] = 8'(k);
        run_cmd(3'b110, 8'hFD, 5, 1'b0);
        chk("s2_A_top", 200'(A_flat[199:192]), 200'd24);
        chk("s2_B_zero", B_flat, 200'h0);

        // 3: illegal op, then illegal size
        illegal_cmd(3'b000, 8'h55, 3'd2, 8'hFD);
        illegal_cmd(3'b001, 8'h66, 3'd6, 8'hFD);

        // 4: mul N=3 with valid gaps and a stray command during load
        for (int k = 0; k < 9; k++) begin
            a_vals[k] = 8'(k + 1);
            b_vals[k] = 8'(-(k + 1));
        end
        gaps[0] = 0; gaps[1] = 2; gaps[2] = 1; gaps[3] = 3; gaps[4] = 0;
        gaps[5] = 1; gaps[6] = 0; gaps[7] = 4; gaps[8] = 1;
        run_cmd(3'b011, 8'h42, 3, 1'b1);

        // 5: reset in the middle of LOAD_B
        send_cmd(3'b010, 8'h11, 3'd2);
        for (int k = 0; k < 4; k++) send_elem(8'(k + 7), 0);
        send_elem(8'h33, 0);
        send_elem(8'h34, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("s5_A", A_flat, 200'h0);
        chk("s5_B", B_flat, 200'h0);
        chk("s5_f", 200'(f), 200'h0);
        chk("s5_opcode", 200'(opcode), 200'h0);
        chk("s5_busy", 200'(busy), 200'h0);
        chk("s5_elem_ready", 200'(elem_ready), 200'h0);
        chk("s5_cmd_ready", 200'(cmd_ready), 200'h1);
        a_vals[0] = 8'h7F;
        run_cmd(3'b101, 8'h22, 1, 1'b0);

`ifdef MATRIX_LOADER_ABORT_EN
        // 6: abort in the first EXEC cycle suppresses the strobe
        send_cmd(3'b100, 8'h01, 3'd1);
        send_elem(8'h05, 0);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        chk("s6_opcode", 200'(opcode), 200'h0);
        chk("s6_cmd_ready", 200'(cmd_ready), 200'h1);
        chk("s6_strobe", 200'(result_strobe), 200'h0);
        chk("s6_A_kept", 200'(A_flat[7:0]), 200'h05);
`endif

        repeat (6) @(posedge clock);
        #1;
        chk("scoreboard_empty", 200'(sb_q.size()), 200'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
